// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
// Exception codes, CP0 map, write masks and bus widths.
package wb_commit_pkg;

  localparam int STALL_W      = 6;
  localparam int MEM_TO_WB_WD = 174;
  localparam int WB_TO_RF_WD  = 38;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic        bd;
    logic [4:0]  excepttype;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  function automatic logic [4:0] exc_code(input logic [4:0] et);
    case (et)
      EXC_INT:  return 5'd0;
      EXC_ADEL: return 5'd4;
      EXC_ADES: return 5'd5;
      EXC_SYS:  return 5'd8;
      EXC_BP:   return 5'd9;
      EXC_RI:   return 5'd10;
      EXC_OV:   return 5'd12;
      default:  return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/cp0_reg.sv
// CP0 register file with Count/Compare timer.
// Exception/ERET updates override same-edge MTC0 on shared fields.
module cp0_reg
  import wb_commit_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc,
  input  logic        eret,
  input  logic        bd,
  input  logic [31:0] pc,
  input  logic [4:0]  code,
  input  logic        bva_we,
  input  logic [31:0] bva,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc
);

  localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

  logic [31:0] count_q, compare_q, badv_q;
  logic [31:0] count_d, compare_d, badv_d;
  logic [31:0] status_d, cause_d, epc_d;
  logic [1:0]  div_q, div_d;
  logic        wr;

  assign wr = we && (wsel == 3'd0);

  always_comb begin
    count_d   = count_q;
    div_d     = div_q;
    compare_d = compare_q;
    badv_d    = badv_q;
    status_d  = status;
    cause_d   = cause;
    epc_d     = epc;
    if (wr && waddr == CP0_COUNT) begin
      count_d = wdata;
      div_d   = 2'd0;
    end else if (div_q == DIV_LAST) begin
      count_d = count_q + 32'd1;
      div_d   = 2'd0;
    end else begin
      div_d = div_q + 2'd1;
    end
    if (wr) begin
      unique case (1'b1)
        waddr == CP0_COMPARE:
          compare_d = wdata;
        waddr == CP0_STATUS:
          status_d = (status & ~STATUS_WMASK)
                   | (wdata & STATUS_WMASK);
        waddr == CP0_CAUSE:
          cause_d = (cause & ~CAUSE_WMASK)
                  | (wdata & CAUSE_WMASK);
        waddr == CP0_EPC:
          epc_d = wdata;
        default: ;
      endcase
    end
    // TI latches on the edge Count reaches Compare
    if (wr && waddr == CP0_COMPARE)
      cause_d[30] = 1'b0;
    else if (count_d == compare_q)
      cause_d[30] = 1'b1;
    if (exc) begin
      if (!status[1]) begin
        epc_d       = bd ? pc - 32'd4 : pc;
        cause_d[31] = bd;
      end
      cause_d[6:2] = code;
      status_d[1]  = 1'b1;
      if (bva_we)
        badv_d = bva;
    end else if (eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      div_q     <= '0;
      compare_q <= '0;
      badv_q    <= '0;
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      compare_q <= compare_d;
      badv_q    <= badv_d;
      status    <= status_d;
      cause     <= cause_d;
      epc       <= epc_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        CP0_BADVADDR: rdata = badv_q;
        CP0_COUNT:    rdata = count_q;
        CP0_COMPARE:  rdata = compare_q;
        CP0_STATUS:   rdata = status;
        CP0_CAUSE:    rdata = cause;
        CP0_EPC:      rdata = epc;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback stage: MEM/WB pipeline register and exception commit.
// Drives RF/HI/LO writes, commit trace and CP0 state.
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  input  logic                    cp0_we,
  input  logic [4:0]              cp0_waddr,
  input  logic [2:0]              cp0_wsel,
  input  logic [31:0]             cp0_wdata,
  input  logic [4:0]              cp0_raddr,
  input  logic [2:0]              cp0_rsel,
  output logic [31:0]             cp0_rdata,
  output logic [31:0]             cp0_status,
  output logic [31:0]             cp0_cause,
  output logic [31:0]             cp0_epc,
  output logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus,
  output logic                    hi_we,
  output logic                    lo_we,
  output logic [31:0]             hi_wdata,
  output logic [31:0]             lo_wdata,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  mem_wb_t     wb_q;
  logic        exc, eret, bva_we;
  logic [31:0] status_arch;
  logic [3:0]  unused_stall;

  assign unused_stall = stall[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wb_q <= '0;
    else if (stall[4] == NO_STOP)
      wb_q <= mem_wb_t'(mem_to_wb_bus);
    else if (stall[5] == NO_STOP)
      wb_q <= '0;
  end

  assign exc = (wb_q.excepttype != EXC_NONE)
            && (wb_q.excepttype != EXC_ERET);
  assign eret = (wb_q.excepttype == EXC_ERET);
  assign bva_we = (wb_q.excepttype == EXC_ADEL)
               || (wb_q.excepttype == EXC_ADES);

  cp0_reg #(
    .COUNT_DIV (COUNT_DIV)
  ) u_cp0_reg (
    .clk    (clk),
    .rst    (rst),
    .we     (cp0_we),
    .waddr  (cp0_waddr),
    .wsel   (cp0_wsel),
    .wdata  (cp0_wdata),
    .raddr  (cp0_raddr),
    .rsel   (cp0_rsel),
    .rdata  (cp0_rdata),
    .exc    (exc),
    .eret   (eret),
    .bd     (wb_q.bd),
    .pc     (wb_q.pc),
    .code   (exc_code(wb_q.excepttype)),
    .bva_we (bva_we),
    .bva    (wb_q.badvaddr),
    .status (status_arch),
    .cause  (cp0_cause),
    .epc    (cp0_epc)
  );

  // EXL visible early so MEM cannot take a second interrupt
  assign cp0_status = status_arch | {30'd0, exc, 1'b0};

  assign wb_to_rf_bus = {wb_q.rf_we, wb_q.rf_waddr, wb_q.rf_wdata};
  assign hi_we        = wb_q.hi_we;
  assign lo_we        = wb_q.lo_we;
  assign hi_wdata     = wb_q.hi_wdata;
  assign lo_wdata     = wb_q.lo_wdata;

  assign debug_wb_pc       = wb_q.pc;
  assign debug_wb_rf_wen   = {4{wb_q.rf_we}};
  assign debug_wb_rf_wnum  = wb_q.rf_waddr;
  assign debug_wb_rf_wdata = wb_q.rf_wdata;

endmodule
